tile_accumulator: RTL and testbench
===================================

# tile_accumulator

Downstream consumer of the combinational `DotProduct` stage. It takes a stream of signed `dp` partial sums, one per tile, and sums `NUM_TILES` consecutive beats plus a per-neuron bias. It then requantizes the sum to `DATA_WIDTH` (rounding arithmetic right shift, optional ReLU, saturation) and presents one output activation per group on a valid/ready handshake. This lets an N-wide dot product serve neurons with fan-in `NUM_TILES*N`.

## Interface
Parameters:
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (width.svh): output activation width.
- `ACC_WIDTH`, default `` `ACC_WIDTH `` (width.svh): width of `dp` and `bias`.
- `NUM_TILES`, default 4: beats per group; legal range ≥1.
- `SUM_WIDTH`, derived: `ACC_WIDTH + $clog2(NUM_TILES) + 1`. This is the internal sum width; overflow is impossible at this width.
- `SHIFT_WIDTH`, derived: `$clog2(SUM_WIDTH)`.

Ports:
- Clocking and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- `clk`  in  1  clock.
- `rst_n`  in  1  async active-low reset.
- `dp_valid`  in  1  `dp` beat valid.
- `dp_ready`  out  1  block can accept a beat.
- `dp`  in  ACC_WIDTH  signed partial sum from `DotProduct`.
- `bias`  in  ACC_WIDTH  signed bias; sampled on the first beat of a group only.
- `shift`  in  SHIFT_WIDTH  right-shift amount; sampled on the first beat.
- `relu_en`  in  1  ReLU enable; sampled on the first beat.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out`  out  DATA_WIDTH  signed requantized activation.
- `out_sat`  out  1  result was clamped.
- `busy`  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, ACCUM, REQUANT, OUTPUT. A beat is accepted when `dp_valid && dp_ready` at a rising edge.
- `dp_ready` = 1 in IDLE and ACCUM, 0 in REQUANT and OUTPUT. It is decoded from state.
- **IDLE**, on an accepted beat:
  - `acc <= sext(bias) + sext(dp)`; capture `shift` and `relu_en`; set `cnt <= 1`.
  - Next state is REQUANT if `NUM_TILES==1`, else ACCUM.
- **ACCUM**, on an accepted beat:
  - `acc <= acc + sext(dp)`; `cnt <= cnt+1`.
  - When the beat is number `NUM_TILES` of the group, go to REQUANT.
  - Cycles with `dp_valid=0` are bubbles and change nothing.
- **REQUANT** lasts exactly one cycle.
  - `r = (acc + (shift>0 ? 1<<(shift-1) : 0)) >>> shift`. This is round-half-up, computed in SUM_WIDTH+1 bits.
  - If `relu_en` and `r<0`, then `r=0`.
  - Clamp `r` to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1]. `out_sat=1` iff clamping changed the value.
  - Register `out` and `out_sat`; set `out_valid<=1`; go to OUTPUT.
- **OUTPUT**: hold `out`, `out_sat` and `out_valid` stable until `out_ready`.
  - On `out_valid && out_ready`: `out_valid<=0` and go to IDLE.
  - Any `dp_valid` asserted in this state is not accepted.
- `shift` ≥ SUM_WIDTH is illegal; behaviour is unspecified and the bench must not drive it.

## Timing
- Reset values (asserted asynchronously; take effect immediately, no clock edge required): state=IDLE, `acc`=0, `cnt`=0, `out`=0, `out_sat`=0, `out_valid`=0, `busy`=0.
- Because state is IDLE during and after reset, `dp_ready` reads 1.
- Latency: if the last beat is accepted at edge E, REQUANT occupies E→E+1 and `out_valid` is high from edge E+1.
- Minimum group period: `NUM_TILES + 2` cycles (NUM_TILES beats, REQUANT, one OUTPUT cycle with `out_ready=1`).
- The next group's first beat can be accepted at the edge after the output handshake. There is no overlap between groups.
- Reset mid-group or mid-OUTPUT discards the partial sum and any pending result.
  - `out_valid` falls asynchronously.
  - The first beat after reset release starts a fresh group.
- `out_ready` high while `out_valid=0` has no effect.

## Test plan
Bench configuration: DATA_WIDTH=8, ACC_WIDTH=20, NUM_TILES=4.
- **Basic:** bias=10, dp=100,200,−50,40, shift=2, relu_en=0 → `out`=75, `out_sat`=0. `out_valid` rises one edge after the 4th beat.
- **Saturation:** bias=0, dp=1000×4, shift=0 → `out`=127, `out_sat`=1. With dp=−1000×4 → `out`=−128, `out_sat`=1.
- **ReLU:** bias=0, dp=−8×4, shift=0, relu_en=1 → `out`=0, `out_sat`=0. Same with relu_en=0 → `out`=−32.
- **Rounding:**
  - sum=6, shift=2 → 2.
  - sum=−6, shift=2 → −1.
  - sum=5, shift=1 → 3.
  - Apply random bubbles between beats; results must be unchanged.
- **Backpressure:** hold `out_ready=0` for 5 cycles with `dp_valid=1` throughout.
  - Required: `out` stable, `dp_ready`=0, `busy`=1, no beat consumed.
  - After `out_ready=1`, the next group sums only the new beats.
- **Reset mid-group:** assert `rst_n=0` after 2 beats.
  - Required: all outputs return to reset values immediately.
  - A following 4-beat group yields its own result, uncontaminated by the abandoned beats.

Source files
------------

// File: rtl/tile_accumulator.sv
// Accumulates NUM_TILES signed partial sums plus a bias, then requantizes the sum
// (round-half-up shift, optional ReLU, saturation) and offers one activation on a valid/ready port.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 20
`endif

module tile_accumulator #(
    parameter int DATA_WIDTH  = `DATA_WIDTH,
    parameter int ACC_WIDTH   = `ACC_WIDTH,
    parameter int NUM_TILES   = 4,
    parameter int SUM_WIDTH   = ACC_WIDTH + $clog2(NUM_TILES) + 1,
    parameter int SHIFT_WIDTH = $clog2(SUM_WIDTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          dp_valid,
    output logic                          dp_ready,
    input  logic signed [ACC_WIDTH-1:0]   dp,
    input  logic signed [ACC_WIDTH-1:0]   bias,
    input  logic        [SHIFT_WIDTH-1:0] shift,
    input  logic                          relu_en,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [DATA_WIDTH-1:0]  out,
    output logic                          out_sat,
    output logic                          busy
);

    localparam int CNT_W = $clog2(NUM_TILES + 1);
    localparam int RW    = SUM_WIDTH + 1;
    localparam logic signed [RW-1:0] OUT_MAX = RW'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [RW-1:0] OUT_MIN = -RW'(2 ** (DATA_WIDTH - 1));

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        REQUANT = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    state_t                        state_q, state_d;
    logic signed [SUM_WIDTH-1:0]   acc_q, acc_d;
    logic        [CNT_W-1:0]       cnt_q, cnt_d;
    logic        [SHIFT_WIDTH-1:0] shift_q, shift_d;
    logic                          relu_q, relu_d;
    logic signed [DATA_WIDTH-1:0]  out_q, out_d;
    logic                          out_sat_q, out_sat_d;
    logic                          out_valid_q, out_valid_d;

    logic signed [SUM_WIDTH-1:0]   dp_ext, bias_ext;
    logic signed [RW-1:0]          acc_ext, half, rounded, rectified, clamped;
    logic                          clamp_hit;

    assign dp_ext   = {{(SUM_WIDTH - ACC_WIDTH){dp[ACC_WIDTH-1]}}, dp};
    assign bias_ext = {{(SUM_WIDTH - ACC_WIDTH){bias[ACC_WIDTH-1]}}, bias};

    // Requantization: one extra bit of headroom so adding the rounding half can never wrap.
    always_comb begin
        acc_ext = {acc_q[SUM_WIDTH-1], acc_q};
        half    = '0;
        if (shift_q != '0) begin
            half = RW'(1) << (shift_q - SHIFT_WIDTH'(1));
        end
        rounded   = (acc_ext + half) >>> shift_q;
        rectified = (relu_q && rounded < 0) ? '0 : rounded;
        clamped   = rectified;
        clamp_hit = 1'b0;
        if (rectified > OUT_MAX) begin
            clamped   = OUT_MAX;
            clamp_hit = 1'b1;
        end else if (rectified < OUT_MIN) begin
            clamped   = OUT_MIN;
            clamp_hit = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        relu_d      = relu_q;
        out_d       = out_q;
        out_sat_d   = out_sat_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (dp_valid) begin
                    acc_d   = bias_ext + dp_ext;
                    shift_d = shift;
                    relu_d  = relu_en;
                    cnt_d   = CNT_W'(1);
                    state_d = (NUM_TILES == 1) ? REQUANT : ACCUM;
                end
            end
            ACCUM: begin
                if (dp_valid) begin
                    acc_d = acc_q + dp_ext;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NUM_TILES - 1)) begin
                        state_d = REQUANT;
                    end
                end
            end
            REQUANT: begin
                out_d       = clamped[DATA_WIDTH-1:0];
                out_sat_d   = clamp_hit;
                out_valid_d = 1'b1;
                state_d     = OUTPUT;
            end
            OUTPUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            out_q       <= '0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            relu_q      <= relu_d;
            out_q       <= out_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Beats are taken only while gathering a group; REQUANT/OUTPUT stall the producer.
    assign dp_ready  = (state_q == IDLE) || (state_q == ACCUM);
    assign busy      = (state_q != IDLE);
    assign out       = out_q;
    assign out_sat   = out_sat_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_tile_accumulator.sv
// Directed bench for tile_accumulator: vector table of 4-beat groups plus
// backpressure and mid-group / mid-output reset sequences.
module tb_tile_accumulator;

    localparam int DW  = 8;
    localparam int AW  = 20;
    localparam int NT  = 4;
    localparam int SW  = AW + $clog2(NT) + 1;
    localparam int SHW = $clog2(SW);

    typedef struct packed {
        logic [AW-1:0]         bias;
        logic [NT-1:0][AW-1:0] dp;
        logic [SHW-1:0]        shift;
        logic                  relu;
        logic [DW-1:0]         exp_out;
        logic                  exp_sat;
        logic                  bubbles;
        logic                  ready_early;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  dp_valid = 1'b0;
    logic                  dp_ready;
    logic signed [AW-1:0]  dp = '0;
    logic signed [AW-1:0]  bias = '0;
    logic [SHW-1:0]        shift = '0;
    logic                  relu_en = 1'b0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic signed [DW-1:0]  out;
    logic                  out_sat;
    logic                  busy;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[11];

    always #5 clk = ~clk;

    tile_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .NUM_TILES(NT)) dut (
        .clk(clk), .rst_n(rst_n),
        .dp_valid(dp_valid), .dp_ready(dp_ready), .dp(dp),
        .bias(bias), .shift(shift), .relu_en(relu_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_sat(out_sat), .busy(busy)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int b, input int d0, input int d1, input int d2,
                                input int d3, input int sh, input bit rl, input int eo,
                                input bit es, input bit bub, input bit re);
        vec_t v;
        v.bias        = AW'(b);
        v.dp[0]       = AW'(d0);
        v.dp[1]       = AW'(d1);
        v.dp[2]       = AW'(d2);
        v.dp[3]       = AW'(d3);
        v.shift       = SHW'(sh);
        v.relu        = rl;
        v.exp_out     = DW'(eo);
        v.exp_sat     = es;
        v.bubbles     = bub;
        v.ready_early = re;
        return v;
    endfunction

    // Feeds the beats of a group; bias/shift/relu carry junk after the first beat.
    task automatic feed_beats(input vec_t v, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            if (v.bubbles) begin
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    dp_valid = 1'b0;
                    dp       = AW'($urandom_range(0, 4095));
                end
            end
            @(negedge clk);
            dp_valid = 1'b1;
            dp       = v.dp[b];
            bias     = (b == 0) ? v.bias : AW'($urandom_range(0, 4095));
            shift    = (b == 0) ? v.shift : SHW'($urandom_range(0, SW - 1));
            relu_en  = (b == 0) ? v.relu : 1'($urandom_range(0, 1));
        end
    endtask

    // Runs a full group and checks latency, result and handshake.
    task automatic run_vec(input vec_t v, input string tag);
        out_ready = v.ready_early;
        feed_beats(v, NT);
        @(negedge clk);
        dp_valid = 1'b0;
        check({tag, "_requant_valid"}, int'(out_valid), 0);
        check({tag, "_requant_ready"}, int'(dp_ready), 0);
        @(negedge clk);
        check({tag, "_valid"}, int'(out_valid), 1);
        check({tag, "_out"}, int'($signed(out)), int'($signed(v.exp_out)));
        check({tag, "_sat"}, int'(out_sat), int'(v.exp_sat));
        check({tag, "_busy"}, int'(busy), 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, int'(out_valid), 0);
        check({tag, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = mk(10, 100, 200, -50, 40, 2, 0, 75, 0, 0, 0);
        vecs[1]  = mk(0, 1000, 1000, 1000, 1000, 0, 0, 127, 1, 0, 0);
        vecs[2]  = mk(0, -1000, -1000, -1000, -1000, 0, 0, -128, 1, 1, 0);
        vecs[3]  = mk(0, -8, -8, -8, -8, 0, 1, 0, 0, 0, 1);
        vecs[4]  = mk(0, -8, -8, -8, -8, 0, 0, -32, 0, 1, 0);
        vecs[5]  = mk(0, 1, 2, 3, 0, 2, 0, 2, 0, 1, 0);
        vecs[6]  = mk(0, -1, -2, -3, 0, 2, 0, -1, 0, 1, 1);
        vecs[7]  = mk(2, 1, 1, 1, 0, 1, 0, 3, 0, 1, 0);
        vecs[8]  = mk(-100, 0, 0, 0, 0, 3, 0, -12, 0, 1, 0);
        vecs[9]  = mk(524287, 524287, 524287, 524287, 0, 15, 0, 64, 0, 0, 0);
        vecs[10] = mk(0, 1, 2, 3, 0, 0, 1, 6, 0, 1, 0);

        // Reset values must appear without any clock edge.
        #1;
        check("rst_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(dp_ready), 1);
        check("rst_out", int'($signed(out)), 0);
        check("rst_sat", int'(out_sat), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result held, producer stalled, no beat swallowed.
        out_ready = 1'b0;
        feed_beats(mk(0, 10, 20, 30, 40, 0, 0, 0, 0, 0, 0), NT);
        @(negedge clk);
        dp       = AW'(555);
        bias     = AW'(777);
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", int'(out_valid), 1);
            check("bp_out", int'($signed(out)), 100);
            check("bp_ready", int'(dp_ready), 0);
            check("bp_busy", int'(busy), 1);
        end
        dp_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release", int'(out_valid), 0);
        run_vec(mk(1, 1, 1, 1, 1, 0, 0, 5, 0, 0, 0), "bp_next");

        // Reset after two beats discards the partial sum.
        feed_beats(mk(50, 1000, 1000, 0, 0, 0, 0, 0, 0, 0, 0), 2);
        @(negedge clk);
        dp_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_ready", int'(dp_ready), 1);
        check("midrst_valid", int'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(mk(0, 3, 3, 3, 3, 1, 0, 6, 0, 0, 0), "after_midrst");

        // Reset while a saturated result waits in OUTPUT.
        feed_beats(mk(0, 1000, 1000, 1000, 1000, 0, 0, 0, 0, 0, 0), NT);
        @(negedge clk);
        dp_valid = 1'b0;
        @(negedge clk);
        check("outrst_pre_valid", int'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("outrst_valid", int'(out_valid), 0);
        check("outrst_out", int'($signed(out)), 0);
        check("outrst_sat", int'(out_sat), 0);
        check("outrst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(mk(-5, -5, -5, -5, -5, 0, 1, 0, 0, 1, 0), "after_outrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
